// File: rtl/frame_key_sequencer.sv
// ---------------------------------------------------------------------------
// frame_key_sequencer
//
// Purpose: cuts a mono PCM stream into frames of 2^FRAME_BITS samples for a
// downstream scrambler. Each frame is emitted as one unbroken run of out_en.
// If the source stops mid-frame, the rest of the frame is filled with zeros.
// A new scrambling key is presented for every frame. That key is either
// stepped from a 24-bit LFSR or taken from a seed loaded by the host.
//
// Build option:
//   KEY_LFSR_EN  defined   -> key steps through x^24+x^23+x^22+x^17+1 per frame
//                undefined -> key is the seed register (LFSR_INIT or last seed)
//
// Ports:
//   clock        in   sampling clock, rising edge
//   reset        in   asynchronous active-high reset
//   in_valid     in   in_sample carries a valid sample
//   in_sample    in   [15:0] signed PCM sample
//   seed_load    in   latch key_seed as the pending seed
//   key_seed     in   [23:0] new seed (0 is taken as 1)
//   out_en       out  sample strobe to scrambler
//   out_sample   out  [15:0] sample to scrambler
//   shift_key    out  [23:0] per-frame key
//   frame_start  out  high with first out_en cycle of each frame
//   frame_index  out  [15:0] index of the frame being emitted
//   underrun     out  one-cycle pulse when a frame starts zero padding
// ---------------------------------------------------------------------------
module frame_key_sequencer #(
    parameter logic [23:0] LFSR_INIT  = 24'h000001,
    parameter int          FRAME_BITS = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_sample,
    input  logic        seed_load,
    input  logic [23:0] key_seed,
    output logic        out_en,
    output logic [15:0] out_sample,
    output logic [23:0] shift_key,
    output logic        frame_start,
    output logic [15:0] frame_index,
    output logic        underrun
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] PAD  = 2'd2;

    logic [1:0]            state;
    logic [FRAME_BITS-1:0] cnt;
    logic [23:0]           key_reg;
    logic [23:0]           pend_seed;
    logic                  pend_vld;
    logic [15:0]           next_index;

    logic        last;
    logic        start;
    logic [23:0] seed_fixed;
    logic [23:0] stepped_key;
    logic [23:0] new_key;

    // An all-zero key would lock the LFSR, so a zero seed is mapped to 1.
    function automatic logic [23:0] sanitize_seed(input logic [23:0] s);
        return (s == 24'h000000) ? 24'h000001 : s;
    endfunction

`ifdef KEY_LFSR_EN
    // Fibonacci form: taps 24,23,22,17 -> bits 23,22,21,16, fed into bit 0.
    function automatic logic [23:0] lfsr_step(input logic [23:0] k);
        return {k[22:0], k[23] ^ k[22] ^ k[21] ^ k[16]};
    endfunction

    assign stepped_key = lfsr_step(key_reg);
`else
    assign stepped_key = key_reg;
`endif

    assign last       = (cnt == '1);
    // A frame begins from IDLE, or right after the final sample of the
    // current frame when the source is still valid (back-to-back).
    assign start      = in_valid && ((state == IDLE) ||
                                     (((state == RUN) || (state == PAD)) && last));
    assign seed_fixed = sanitize_seed(key_seed);
    // A seed arriving in the start cycle itself takes precedence over an
    // older pending one.
    assign new_key    = seed_load ? seed_fixed :
                        pend_vld  ? pend_seed  : stepped_key;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            out_en      <= 1'b0;
            out_sample  <= 16'h0000;
            shift_key   <= 24'h000000;
            frame_start <= 1'b0;
            frame_index <= 16'h0000;
            next_index  <= 16'h0000;
            underrun    <= 1'b0;
            key_reg     <= LFSR_INIT;
            pend_seed   <= 24'h000000;
            pend_vld    <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            underrun    <= 1'b0;

            if (start) begin
                pend_vld <= 1'b0;
            end else if (seed_load) begin
                pend_vld  <= 1'b1;
                pend_seed <= seed_fixed;
            end

            if (start) begin
                state       <= RUN;
                cnt         <= '0;
                out_en      <= 1'b1;
                out_sample  <= in_sample;
                frame_start <= 1'b1;
                key_reg     <= new_key;
                shift_key   <= new_key;
                frame_index <= next_index;
                next_index  <= next_index + 16'd1;
            end else begin
                case (state)
                    RUN: begin
                        if (last) begin
                            state      <= IDLE;
                            cnt        <= '0;
                            out_en     <= 1'b0;
                            out_sample <= 16'h0000;
                        end else if (in_valid) begin
                            out_sample <= in_sample;
                            cnt        <= cnt + 1'b1;
                        end else begin
                            state      <= PAD;
                            out_sample <= 16'h0000;
                            underrun   <= 1'b1;
                            cnt        <= cnt + 1'b1;
                        end
                    end
                    PAD: begin
                        // Input is dropped here; only the frame length matters.
                        if (last) begin
                            state      <= IDLE;
                            cnt        <= '0;
                            out_en     <= 1'b0;
                            out_sample <= 16'h0000;
                        end else begin
                            out_sample <= 16'h0000;
                            cnt        <= cnt + 1'b1;
                        end
                    end
                    default: begin
                        state      <= IDLE;
                        out_en     <= 1'b0;
                        out_sample <= 16'h0000;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_frame_key_sequencer.sv
// ---------------------------------------------------------------------------
// tb_frame_key_sequencer
//
// Purpose: directed self-checking bench for frame_key_sequencer with default
// parameters (128-sample frames, LFSR_INIT = 1). Expected keys follow the
// KEY_LFSR_EN build option.
// ---------------------------------------------------------------------------
module tb_frame_key_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_sample = 16'h0000;
    logic        seed_load = 1'b0;
    logic [23:0] key_seed = 24'h000000;
    logic        out_en;
    logic [15:0] out_sample;
    logic [23:0] shift_key;
    logic        frame_start;
    logic [15:0] frame_index;
    logic        underrun;

    int n_cmp = 0;
    int n_err = 0;

`ifdef KEY_LFSR_EN
    localparam logic [23:0] KA0 = 24'h000002;
    localparam logic [23:0] KA1 = 24'h000004;
    localparam logic [23:0] KA2 = 24'h000008;
    localparam logic [23:0] KA3 = 24'h000010;
    localparam logic [23:0] KA4 = 24'h000020;
    localparam logic [23:0] KS5 = 24'h222223;
    localparam logic [23:0] K6  = 24'h444447;
`else
    localparam logic [23:0] KA0 = 24'h000001;
    localparam logic [23:0] KA1 = 24'h000001;
    localparam logic [23:0] KA2 = 24'h000001;
    localparam logic [23:0] KA3 = 24'h000001;
    localparam logic [23:0] KA4 = 24'h000001;
    localparam logic [23:0] KS5 = 24'h111111;
    localparam logic [23:0] K6  = 24'h111111;
`endif

    typedef struct {
        logic        vld;
        logic [15:0] smp;
        logic        sl;
        logic [23:0] seed;
        logic        e_en;
        logic [15:0] e_smp;
        logic        e_fs;
        logic        e_ur;
        logic [15:0] e_idx;
        logic [23:0] e_key;
    } vec_t;

    vec_t tbl [6];

    frame_key_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_sample   (in_sample),
        .seed_load   (seed_load),
        .key_seed    (key_seed),
        .out_en      (out_en),
        .out_sample  (out_sample),
        .shift_key   (shift_key),
        .frame_start (frame_start),
        .frame_index (frame_index),
        .underrun    (underrun)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    task automatic check_out(input string tag, input logic e_en, input logic [15:0] e_smp,
                             input logic e_fs, input logic e_ur, input logic [15:0] e_idx,
                             input logic [23:0] e_key);
        chk({tag, ".out_en"},      32'(out_en),      32'(e_en));
        chk({tag, ".out_sample"},  32'(out_sample),  32'(e_smp));
        chk({tag, ".frame_start"}, 32'(frame_start), 32'(e_fs));
        chk({tag, ".underrun"},    32'(underrun),    32'(e_ur));
        chk({tag, ".frame_index"}, 32'(frame_index), 32'(e_idx));
        chk({tag, ".shift_key"},   32'(shift_key),   32'(e_key));
    endtask

    task automatic drive(input logic v, input logic [15:0] s, input logic sl, input logic [23:0] sd);
        in_valid  = v;
        in_sample = s;
        seed_load = sl;
        key_seed  = sd;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        drive(1'b0, 16'h0000, 1'b0, 24'h000000);
        @(negedge clock);
        reset = 1'b0;
    endtask

    function automatic logic [23:0] ramp_key(input int f);
        case (f)
            0:       return KA0;
            1:       return KA1;
            2:       return KA2;
            default: return KA3;
        endcase
    endfunction

    function automatic logic [23:0] seed_key(input int f);
        case (f)
            0:       return KA0;
            1:       return 24'hABCDEF;
            2:       return 24'h5A5A5A;
            3:       return 24'h000001;
            4:       return 24'h111111;
            default: return KS5;
        endcase
    endfunction

    initial begin
        // Reset state
        repeat (2) @(negedge clock);
        check_out("reset", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 24'h000000);
        reset = 1'b0;

        // Short frame start, underrun and dropped input in PAD
        tbl[0] = '{1'b0, 16'h1234, 1'b0, 24'h0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0, 24'h0};
        tbl[1] = '{1'b1, 16'h8000, 1'b0, 24'h0, 1'b1, 16'h8000, 1'b1, 1'b0, 16'h0, KA0};
        tbl[2] = '{1'b1, 16'h7FFF, 1'b0, 24'h0, 1'b1, 16'h7FFF, 1'b0, 1'b0, 16'h0, KA0};
        tbl[3] = '{1'b1, 16'hFFFF, 1'b0, 24'h0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 16'h0, KA0};
        tbl[4] = '{1'b0, 16'hABCD, 1'b0, 24'h0, 1'b1, 16'h0000, 1'b0, 1'b1, 16'h0, KA0};
        tbl[5] = '{1'b1, 16'h5555, 1'b0, 24'h0, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0, KA0};
        for (int i = 0; i < 6; i++) begin
            drive(tbl[i].vld, tbl[i].smp, tbl[i].sl, tbl[i].seed);
            @(negedge clock);
            check_out($sformatf("vec%0d", i), tbl[i].e_en, tbl[i].e_smp, tbl[i].e_fs,
                      tbl[i].e_ur, tbl[i].e_idx, tbl[i].e_key);
        end
        drive(1'b0, 16'h0000, 1'b0, 24'h000000);
        for (int k = 0; k < 123; k++) begin
            @(negedge clock);
            check_out("vec_pad", 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, KA0);
        end
        @(negedge clock);
        chk("vec_end.out_en", 32'(out_en), 32'd0);

        // Ramp over four back-to-back frames
        pulse_reset();
        for (int i = 0; i < 512; i++) begin
            drive(1'b1, i[15:0], 1'b0, 24'h000000);
            @(negedge clock);
            check_out("ramp", 1'b1, i[15:0], (i % 128) == 0, 1'b0,
                      16'(i / 128), ramp_key(i / 128));
        end
        drive(1'b0, 16'h0000, 1'b0, 24'h000000);
        @(negedge clock);
        chk("ramp_end.out_en", 32'(out_en), 32'd0);

        // Source stops after 50 samples: 78 padded zeros, one underrun pulse
        for (int j = 0; j < 50; j++) begin
            drive(1'b1, 16'(16'h1000 + j), 1'b0, 24'h000000);
            @(negedge clock);
            check_out("ur_data", 1'b1, 16'(16'h1000 + j), j == 0, 1'b0, 16'd4, KA4);
        end
        drive(1'b0, 16'h0000, 1'b0, 24'h000000);
        for (int k = 0; k < 78; k++) begin
            @(negedge clock);
            check_out("ur_pad", 1'b1, 16'h0000, 1'b0, k == 0, 16'd4, KA4);
        end
        @(negedge clock);
        chk("ur_end.out_en", 32'(out_en), 32'd0);
        chk("ur_end.underrun", 32'(underrun), 32'd0);

        // Seed loading: pending seed, overwrite, zero seed, same-cycle seed
        pulse_reset();
        for (int i = 0; i < 768; i++) begin
            logic        sl;
            logic [23:0] sd;
            int          f;
            int          s;
            f  = i / 128;
            s  = i % 128;
            sl = 1'b0;
            sd = 24'h000000;
            if (f == 0 && s == 10) begin sl = 1'b1; sd = 24'hABCDEF; end
            if (f == 1 && s == 5)  begin sl = 1'b1; sd = 24'h000000; end
            if (f == 1 && s == 6)  begin sl = 1'b1; sd = 24'h5A5A5A; end
            if (f == 2 && s == 3)  begin sl = 1'b1; sd = 24'h000000; end
            if (f == 4 && s == 0)  begin sl = 1'b1; sd = 24'h111111; end
            drive(1'b1, i[15:0], sl, sd);
            @(negedge clock);
            check_out("seed", 1'b1, i[15:0], s == 0, 1'b0, 16'(f), seed_key(f));
        end
        drive(1'b0, 16'h0000, 1'b0, 24'h000000);
        @(negedge clock);
        chk("seed_end.out_en", 32'(out_en), 32'd0);

        // Reset in the middle of a frame, with a seed still pending
        for (int j = 0; j <= 60; j++) begin
            drive(1'b1, 16'(16'h2000 + j), j == 5, 24'h777777);
            @(negedge clock);
            check_out("mid", 1'b1, 16'(16'h2000 + j), j == 0, 1'b0, 16'd6, K6);
        end
        reset = 1'b1;
        #1;
        check_out("mid_rst", 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 24'h000000);
        drive(1'b0, 16'h0000, 1'b0, 24'h000000);
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            chk("mid_idle.out_en", 32'(out_en), 32'd0);
        end
        drive(1'b1, 16'h3333, 1'b0, 24'h000000);
        @(negedge clock);
        check_out("mid_restart", 1'b1, 16'h3333, 1'b1, 1'b0, 16'h0000, KA0);
        drive(1'b0, 16'h0000, 1'b0, 24'h000000);
        for (int k = 0; k < 127; k++) begin
            @(negedge clock);
            chk("mid_pad.out_en", 32'(out_en), 32'd1);
            chk("mid_pad.underrun", 32'(underrun), 32'(k == 0));
        end
        @(negedge clock);
        chk("mid_end.out_en", 32'(out_en), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
